tile_flusher: RTL and testbench

- Reads a fully painted 20x45 tile out of the tile BRAM after the painter finishes.
- Streams each pixel's colour, with its absolute framebuffer address, to the framebuffer writer over a valid/ready interface.
- Sits between the tile BRAM's second read port and the framebuffer arbiter.
- Tile BRAM reads have 2-cycle latency, so a small credit-tracked FIFO absorbs backpressure.

---
 rtl/tile_pkg.sv | 45 ++++
 rtl/tile_flusher_if.sv | 13 +
 rtl/pipeline.sv | 55 +++++
 rtl/pixel_fifo.sv | 92 +++++++++
 rtl/tile_flusher_checker.sv | 11 +
 rtl/tile_flusher.sv | 174 +++++++++++++++++
 tb/tb_tile_flusher.sv | 194 +++++++++++++++++++
 7 files changed

// File: rtl/tile_pkg.sv
// Shared constants, types and address arithmetic for the tile flusher.
// A tile is 20x45 pixels placed inside a 320-pixel-wide framebuffer.
package tile_pkg;

    localparam int TILE_WIDTH   = 20;
    localparam int TILE_HEIGHT  = 45;
    localparam int SCREEN_WIDTH = 320;

    localparam int DEPTH_MSB = 31;
    localparam int DEPTH_LSB = 16;
    localparam int COLOR_MSB = 15;
    localparam int COLOR_LSB = 0;

    localparam logic [4:0] X_LAST = 5'(TILE_WIDTH - 1);
    localparam logic [5:0] Y_LAST = 6'(TILE_HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } flush_state_e;

    typedef struct packed {
        logic [4:0] x;
        logic [5:0] y;
    } tag_t;

    typedef struct packed {
        logic        last;
        logic [15:0] addr;
        logic [15:0] color;
    } beat_t;

    // Address wraps modulo 2^16; callers keep the tile on screen.
    function automatic logic [15:0] calc_pixel_addr(input logic [7:0] y_off, input logic [5:0] y,
                                                    input logic [8:0] x_off, input logic [4:0] x);
        logic [7:0]  row;
        logic [15:0] prod;
        row  = y_off + {2'b00, y};
        prod = {8'b0000_0000, row} * 16'(SCREEN_WIDTH);
        return prod + {7'b000_0000, x_off} + {11'b000_0000_0000, x};
    endfunction

endpackage

// File: rtl/tile_flusher_if.sv
// Pixel stream from the flusher to the framebuffer writer (valid/ready).
interface tile_flusher_if;
    logic        pixel_valid;
    logic        pixel_ready;
    logic [15:0] pixel_addr;
    logic [15:0] pixel_color;
    logic        pixel_last;

    modport master (output pixel_valid, output pixel_addr, output pixel_color,
                    output pixel_last, input pixel_ready);
    modport slave  (input pixel_valid, input pixel_addr, input pixel_color,
                    input pixel_last, output pixel_ready);
endinterface

// File: rtl/pipeline.sv
// Fixed-latency valid/data delay line with a synchronous clear of all valids.
module pipeline #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic [STAGES-1:0] stage_valid
);
    logic [STAGES-1:0] valid_q, valid_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];

    // Shift every stage forward one slot; clear kills all valids.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < STAGES; i++) begin
            data_d[i] = data_q[i];
        end
        if (clear) begin
            valid_d = '0;
        end else begin
            valid_d[0] = in_valid;
            data_d[0]  = in_data;
            for (int i = 1; i < STAGES; i++) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
    end

    // Stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_valid   = valid_q[STAGES-1];
    assign out_data    = data_q[STAGES-1];
    assign stage_valid = valid_q;
endmodule

// File: rtl/pixel_fifo.sv
// Synchronous FIFO; a push onto a full FIFO is accepted only alongside a pop.
module pixel_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok_s, pop_ok_s;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        logic [AW-1:0] n;
        if (p == AW'(DEPTH - 1)) begin
            n = '0;
        end else begin
            n = p + AW'(1);
        end
        return n;
    endfunction

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign push_ok_s = push && (!full || pop);
    assign pop_ok_s  = pop && !empty;

    // Pointer, occupancy and storage updates.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push_ok_s) begin
                mem_d[wr_q] = push_data;
                wr_d        = ptr_inc(wr_q);
            end else begin
                wr_d = wr_q;
            end
            if (pop_ok_s) begin
                rd_d = ptr_inc(rd_q);
            end else begin
                rd_d = rd_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage; contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign pop_data = mem_q[rd_q];
    assign count    = count_q;
endmodule

// File: rtl/tile_flusher_checker.sv
// Protocol checks for the flusher's output buffer.
module tile_flusher_checker (
    input logic clk,
    input logic rst,
    input logic push,
    input logic pop,
    input logic full
);
    // Credit accounting must make an unbacked push into a full buffer impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
endmodule

// File: rtl/tile_flusher.sv
// Streams a painted 20x45 tile from BRAM to the framebuffer writer, row-major,
// with credit-limited reads so a stalled consumer never overflows the buffer.
module tile_flusher
    import tile_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           active,
    input  logic [8:0]     x_offset,
    input  logic [7:0]     y_offset,
    output logic [9:0]     tile_bram_read_addr,
    input  logic [31:0]    tile_bram_read_data,
    tile_flusher_if.master pix,
    output logic           done
);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int TAG_W = $bits(tag_t);

    flush_state_e  state_q, state_d;
    logic [4:0]    x_q, x_d;
    logic [5:0]    y_q, y_d;
    logic [8:0]    xo_q, xo_d;
    logic [7:0]    yo_q, yo_d;
    logic [9:0]    raddr_q, raddr_d;
    logic          last_sent_q, last_sent_d;

    logic          issue_s, flush_s, credit_ok_s, drained_s;
    logic          valid_s, pop_s, push_s, last_xfer_s;
    logic          fifo_full_s, fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    logic [1:0]    stage_valid_s, inflight_s;
    tag_t          tag_in_s, tag_out_s;
    beat_t         push_beat_s, head_s;
    logic          unused_depth_s;

    assign unused_depth_s = ^tile_bram_read_data[DEPTH_MSB:DEPTH_LSB];
    assign tag_in_s       = {x_q, y_q};

    // Tags travel alongside the 2-cycle BRAM read so data lands with its coordinates.
    pipeline #(.WIDTH(TAG_W), .STAGES(2)) u_tag_pipe (
        .clk         (clk),
        .rst         (rst),
        .clear       (flush_s),
        .in_valid    (issue_s),
        .in_data     (tag_in_s),
        .out_valid   (push_s),
        .out_data    (tag_out_s),
        .stage_valid (stage_valid_s)
    );

    assign push_beat_s.last  = (tag_out_s.x == X_LAST) && (tag_out_s.y == Y_LAST);
    assign push_beat_s.addr  = calc_pixel_addr(yo_q, tag_out_s.y, xo_q, tag_out_s.x);
    assign push_beat_s.color = tile_bram_read_data[COLOR_MSB:COLOR_LSB];

    pixel_fifo #(.WIDTH($bits(beat_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_s),
        .push      (push_s),
        .push_data (push_beat_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    tile_flusher_checker u_chk (
        .clk  (clk),
        .rst  (rst),
        .push (push_s),
        .pop  (pop_s),
        .full (fifo_full_s)
    );

    assign inflight_s  = {1'b0, stage_valid_s[0]} + {1'b0, stage_valid_s[1]};
    // Reads already in flight hold a slot, so issuing never outruns buffer space.
    assign credit_ok_s = ({1'b0, fifo_count_s} + (CW+1)'(inflight_s)) < (CW+1)'(FIFO_DEPTH);
    assign valid_s     = !fifo_empty_s;
    assign pop_s       = valid_s && pix.pixel_ready;
    assign last_xfer_s = pop_s && head_s.last;
    assign drained_s   = (inflight_s == 2'd0)
                       && ((fifo_count_s == '0) || ((fifo_count_s == CW'(1)) && pop_s))
                       && (last_sent_q || last_xfer_s);

    // Next-state, read issue and coordinate walk.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        xo_d        = xo_q;
        yo_d        = yo_q;
        raddr_d     = raddr_q;
        last_sent_d = last_sent_q || last_xfer_s;
        issue_s     = 1'b0;
        flush_s     = 1'b0;
        if (!active) begin
            state_d     = ST_IDLE;
            flush_s     = 1'b1;
            raddr_d     = 10'd0;
            last_sent_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    xo_d        = x_offset;
                    yo_d        = y_offset;
                    x_d         = 5'd0;
                    y_d         = 6'd0;
                    raddr_d     = 10'd0;
                    last_sent_d = 1'b0;
                    state_d     = ST_STREAM;
                end
                ST_STREAM: begin
                    if (credit_ok_s) begin
                        issue_s = 1'b1;
                        if (x_q == X_LAST) begin
                            x_d = 5'd0;
                            if (y_q == Y_LAST) begin
                                state_d = ST_DRAIN;
                            end else begin
                                y_d     = y_q + 6'd1;
                                raddr_d = raddr_q + 10'd1;
                            end
                        end else begin
                            x_d     = x_q + 5'd1;
                            raddr_d = raddr_q + 10'd1;
                        end
                    end else begin
                        issue_s = 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (drained_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // State and walk registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            x_q         <= 5'd0;
            y_q         <= 6'd0;
            xo_q        <= 9'd0;
            yo_q        <= 8'd0;
            raddr_q     <= 10'd0;
            last_sent_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            xo_q        <= xo_d;
            yo_q        <= yo_d;
            raddr_q     <= raddr_d;
            last_sent_q <= last_sent_d;
        end
    end

    assign tile_bram_read_addr = raddr_q;
    assign done                = (state_q == ST_DONE);
    assign pix.pixel_valid     = valid_s;
    assign pix.pixel_addr      = valid_s ? head_s.addr  : 16'd0;
    assign pix.pixel_color     = valid_s ? head_s.color : 16'd0;
    assign pix.pixel_last      = valid_s && head_s.last;
endmodule

// File: tb/tb_tile_flusher.sv
// Directed/randomised bench for tile_flusher against a queue-based model of the tile stream.
module tb_tile_flusher;
    logic        clk = 1'b0;
    logic        rst;
    logic        active;
    logic [8:0]  x_offset;
    logic [7:0]  y_offset;
    logic [9:0]  rd_addr;
    logic [31:0] rd_data;
    logic        done;

    tile_flusher_if pix ();

    tile_flusher #(.FIFO_DEPTH(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .active              (active),
        .x_offset            (x_offset),
        .y_offset            (y_offset),
        .tile_bram_read_addr (rd_addr),
        .tile_bram_read_data (rd_data),
        .pix                 (pix),
        .done                (done)
    );

    always #5 clk = ~clk;

    // Tile BRAM model: address registered, then data registered (2-cycle read).
    logic [31:0] mem [1024];
    logic [9:0]  d1;
    logic [31:0] d2;
    always @(posedge clk) begin
        d1 <= rd_addr;
        d2 <= mem[d1];
    end
    assign rd_data = d2;

    int          checks   = 0;
    int          failures = 0;
    logic [32:0] exp_q [$];
    logic [15:0] first_addr, last_addr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, pix.pixel_valid, 0);
        check({tag, "_addr"},  pix.pixel_addr, 0);
        check({tag, "_color"}, pix.pixel_color, 0);
        check({tag, "_last"},  pix.pixel_last, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_rdaddr"}, rd_addr, 0);
    endtask

    // mode 0: ready always 1; mode 1: ~30% random ready; mode 2: ready 0 for the first 50 STREAM cycles.
    task automatic run_flush(input logic [8:0] xo, input logic [7:0] yo, input int mode, input int abort_after);
        logic [32:0] got, exp, held;
        bit          stalled, r, fin;
        int          nb, last_idx;
        exp_q.delete();
        for (int y = 0; y < 45; y++) begin
            for (int x = 0; x < 20; x++) begin
                exp_q.push_back({(x == 19 && y == 44) ? 1'b1 : 1'b0,
                                 16'((int'(yo) + y) * 320 + int'(xo) + x),
                                 mem[y*20 + x][15:0]});
            end
        end
        x_offset = xo;
        y_offset = yo;
        active   = 1'b1;
        stalled  = 1'b0;
        held     = '0;
        nb       = 0;
        last_idx = -1;
        fin      = 1'b0;
        for (int idx = 0; idx < 20000 && !fin; idx++) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = ($urandom_range(0, 9) < 3);
                default: r = (idx >= 51);
            endcase
            pix.pixel_ready = r;
            got = {pix.pixel_last, pix.pixel_addr, pix.pixel_color};
            if (stalled) check("stall_hold", {pix.pixel_valid, got}, {1'b1, held});
            if (mode == 1) check("fifo_bound", dut.fifo_count_s <= 4, 1);
            if (mode == 2 && idx == 50) begin
                check("stall_rd_addr", rd_addr, 4);
                check("stall_fifo_full", dut.fifo_count_s, 4);
                check("stall_head", {pix.pixel_valid, got}, {1'b1, exp_q[0]});
            end
            if (done) begin
                check("done_after_last", idx, last_idx + 1);
                check("beats_total", nb, 900);
                check("queue_drained", exp_q.size(), 0);
                fin = 1'b1;
            end else if (pix.pixel_valid && r) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    exp = exp_q.pop_front();
                    check("beat", got, exp);
                end
                if (nb == 0) begin
                    first_addr = got[31:16];
                    if (mode == 0) check("first_beat_latency", idx, 4);
                end
                nb++;
                if (got[32]) begin
                    last_idx  = idx;
                    last_addr = got[31:16];
                end
                if (abort_after != 0 && nb == abort_after) begin
                    tick();
                    active = 1'b0;
                    tick();
                    check("abort_valid", pix.pixel_valid, 0);
                    check("abort_done", done, 0);
                    check("abort_rdaddr", rd_addr, 0);
                    fin = 1'b1;
                end
            end
            stalled = pix.pixel_valid && !r;
            held    = got;
            if (!fin) tick();
        end
        if (!fin) check("timeout", 1, 0);
        if (abort_after == 0) begin
            active = 1'b0;
            tick();
            check("done_clear", done, 0);
        end
        pix.pixel_ready = 1'b0;
        tick();
    endtask

    initial begin
        rst             = 1'b1;
        active          = 1'b0;
        x_offset        = 9'd0;
        y_offset        = 8'd0;
        pix.pixel_ready = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
        tick(); tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Data word = address, origin tile.
        run_flush(9'd0, 8'd0, 0, 0);
        check("a_first_addr", first_addr, 0);
        check("a_last_addr", last_addr, 14099);

        for (int i = 0; i < 1024; i++) mem[i] = $urandom;

        // Bottom-right corner of the screen.
        run_flush(9'd300, 8'd135, 0, 0);
        check("b_first_addr", first_addr, 43500);
        check("b_last_addr", last_addr, 57599);

        run_flush(9'd17, 8'd60, 1, 0);
        run_flush(9'd5, 8'd9, 2, 0);

        // Abort after 100 beats, then a full restart from (0,0).
        run_flush(9'd40, 8'd20, 0, 100);
        run_flush(9'd40, 8'd20, 0, 0);
        check("e_restart_first", first_addr, 6440);

        // Reset with two reads in flight.
        x_offset = 9'd0;
        y_offset = 8'd0;
        active   = 1'b1;
        tick(); tick(); tick();
        check("f_inflight", dut.inflight_s, 2);
        rst = 1'b1;
        tick();
        check_all_zero("f_rst");
        rst = 1'b0;
        run_flush(9'd0, 8'd0, 0, 0);
        check("f_first_addr", first_addr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
